eth_frame_buf: RTL and testbench

Single-frame staging buffer directly upstream of the 10BASE-T Manchester transmitter. Accepts an Ethernet frame (destination MAC through payload, no preamble/SFD/FCS) as a byte stream, stores it, zero-pads it to the minimum length, then hands it to the transmitter through a synchronous read port plus a `start` pulse. The transmitter computes and appends the FCS. The buffer refills only after the transmitter reports the frame sent.

---
 rtl/eth_pkg.sv | 16 +
 rtl/eth_frame_ram.sv | 34 +++
 rtl/eth_frame_buf.sv | 133 +++++++++++++
 tb/tb_eth_frame_buf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the staging-buffer state encoding.
// Also used by the Manchester transmitter.
package eth_pkg;

    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_MAX_LEN = 1514;

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_PAD       = 3'd1,
        ST_ARM       = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } eth_buf_state_t;

endpackage

// File: rtl/eth_frame_ram.sv
// Simple dual-port frame store: one write port and one registered read port.
// Reads whose range mask is low return 0x00.
module eth_frame_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    input  logic          i_rmask,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(1<<AW)-1];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rdata <= 8'h00;
        else
            r_rdata <= i_rmask ? r_mem[i_raddr] : 8'h00;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/eth_frame_buf.sv
// Single-frame staging buffer feeding the 10BASE-T transmitter.
// Define ETH_FRAME_PAD_EN to zero-pad short frames up to MIN_LEN.
module eth_frame_buf
    import eth_pkg::*;
#(
    parameter int MAX_LEN = ETH_MAX_LEN,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int AW      = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] len,
    output logic          start,
    input  logic          tx_busy,
    output logic          err
);

    if (MIN_LEN < 1 || MIN_LEN > MAX_LEN || (1 << AW) <= MAX_LEN) begin : g_bad_cfg
        $error("eth_frame_buf: inconsistent MIN_LEN/MAX_LEN/AW");
    end

    localparam logic [AW-1:0] L_MAX = AW'(MAX_LEN);
`ifdef ETH_FRAME_PAD_EN
    localparam logic [AW-1:0] L_MIN = AW'(MIN_LEN);
`endif

    eth_buf_state_t r_state;
    logic [AW-1:0]  r_cnt;
    logic [AW-1:0]  r_len;
    logic           r_ovf;
    logic           r_start;
    logic           r_err;

    logic           w_fill;
    logic           w_room;
    logic           w_ovf;
    logic [AW-1:0]  w_cnt_nx;
    logic           w_we;
    logic [7:0]     w_wdata;

    assign w_fill   = (r_state == ST_FILL);
    assign w_room   = (r_cnt < L_MAX);
    // Include the byte being dropped right now, so an oversize last byte still errors.
    assign w_ovf    = r_ovf | ~w_room;
    assign w_cnt_nx = r_cnt + AW'(1);
    assign w_we     = (w_fill & in_valid & w_room) | (r_state == ST_PAD);
    assign w_wdata  = w_fill ? in_data : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (in_valid) begin
                        if (w_room)
                            r_cnt <= w_cnt_nx;
                        else
                            r_ovf <= 1'b1;
                        if (in_last) begin
                            if (w_ovf) begin
                                r_err <= 1'b1;
                                r_cnt <= '0;
                                r_ovf <= 1'b0;
                            end
`ifdef ETH_FRAME_PAD_EN
                            else if (w_cnt_nx < L_MIN)
                                r_state <= ST_PAD;
`endif
                            else
                                r_state <= ST_ARM;
                        end
                    end
                end
`ifdef ETH_FRAME_PAD_EN
                ST_PAD: begin
                    r_cnt <= w_cnt_nx;
                    if (w_cnt_nx == L_MIN)
                        r_state <= ST_ARM;
                end
`endif
                ST_ARM: begin
                    r_len <= r_cnt;
                    if (!tx_busy) begin
                        r_start <= 1'b1;
                        r_state <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy)
                        r_state <= ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        r_cnt   <= '0;
                        r_state <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    eth_frame_ram #(.AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_cnt),
        .i_wdata (w_wdata),
        .i_raddr (rd_addr),
        .i_rmask (rd_addr < r_len),
        .o_rdata (rd_data)
    );

    assign in_ready = w_fill;
    assign len      = r_len;
    assign start    = r_start;
    assign err      = r_err;

endmodule

// File: tb/tb_eth_frame_buf.sv
// Scoreboard bench for eth_frame_buf: stimulus queues expected start/err/read events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_eth_frame_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [10:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic [10:0] len;
    logic        start;
    logic        tx_busy = 1'b0;
    logic        err;

    eth_frame_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .len      (len),
        .start    (start),
        .tx_busy  (tx_busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int q_st_cyc[$];
    int q_st_len[$];
    int q_err[$];
    int q_rd[$];
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;
    always @(posedge clk) rd_req_d <= rd_req;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT output event must match the head of its queue.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            if (q_st_cyc.size() == 0) chk("unexpected_start", 1, 0);
            else begin
                chk("start_cycle", cyc, q_st_cyc.pop_front());
                chk("start_len", int'(len), q_st_len.pop_front());
            end
        end
        if (err === 1'b1) begin
            if (q_err.size() == 0) chk("unexpected_err", 1, 0);
            else chk("err_cycle", cyc, q_err.pop_front());
        end
        if (rd_req_d) begin
            if (q_rd.size() == 0) chk("rd_underflow", 1, 0);
            else chk("rd_data", int'(rd_data), q_rd.pop_front());
        end
    end

    function automatic int exp_len(input int n);
`ifdef ETH_FRAME_PAD_EN
        return (n < 60) ? 60 : n;
`else
        return n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int off, input bit push);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + off);
            in_last  = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (n > 1514) q_err.push_back(cyc);
        else if (push) begin
            q_st_cyc.push_back(cyc + 1 + exp_len(n) - n);
            q_st_len.push_back(exp_len(n));
        end
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (start !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("start_timeout", 0, 1);
        tick();
    endtask

    // Transmitter model: busy after start, read back the buffer, then go idle.
    // A junk byte is offered while busy and must be ignored.
    task automatic do_tx(input int nb, input int off, input int el, input int rd_n);
        wait_start();
        tx_busy  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        tick();
        chk("ready_busy", int'(in_ready), 0);
        for (int a = 0; a < rd_n; a++) begin
            rd_addr = 11'(a);
            rd_req  = 1'b1;
            q_rd.push_back((a < nb) ? ((a + off) & 255) : 0);
            tick();
        end
        rd_req = 1'b0;
        chk("len_stable", int'(len), el);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("ready_busy2", int'(in_ready), 0);
        tx_busy = 1'b0;
        tick();
        chk("ready_back", int'(in_ready), 1);
    endtask

    task automatic reset_chk();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_start", int'(start), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_len", int'(len), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 reset_chk();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 64-byte frame, no padding, plus one read past the end
        send(64, 0, 1'b1);
        do_tx(64, 0, 64, 65);

        // short frame: padded or not depending on build
        send(14, 8'h30, 1'b1);
        do_tx(14, 8'h30, exp_len(14), 61);

        // oversize frame is dropped with a single err pulse
        send(1600, 0, 1'b1);
        chk("ovf_ready", int'(in_ready), 1);
        repeat (5) tick();
        chk("ovf_ready2", int'(in_ready), 1);
        send(60, 8'h11, 1'b1);
        do_tx(60, 8'h11, 60, 4);

        // transmitter still busy when the frame is armed
        tx_busy = 1'b1;
        send(60, 5, 1'b0);
        repeat (6) tick();
        chk("ready_held", int'(in_ready), 0);
        tx_busy = 1'b0;
        q_st_cyc.push_back(cyc + 1);
        q_st_len.push_back(60);
        do_tx(60, 5, 60, 2);

        // back-to-back frames
        send(20, 8'h40, 1'b1);
        do_tx(20, 8'h40, exp_len(20), 3);
        send(25, 8'h60, 1'b1);
        do_tx(25, 8'h60, exp_len(25), 3);

        // reset while padding (or parked in ARM when padding is compiled out)
        tx_busy = 1'b1;
        send(14, 8'h10, 1'b0);
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #2 reset_chk();
        tick();
        rst_n = 1'b1;
        tx_busy = 1'b0;
        tick();
        send(60, 8'h22, 1'b1);
        do_tx(60, 8'h22, 60, 3);

        // reset while waiting for the transmitter to go idle
        send(30, 8'h20, 1'b1);
        wait_start();
        tx_busy = 1'b1;
        tick();
        rd_addr = 11'd3;
        tick();
        tick();
        chk("rd_pre_reset", int'(rd_data), 8'h23);
        chk("len_pre_reset", int'(len), exp_len(30));
        #3 rst_n = 1'b0;
        #2 reset_chk();
        tick();
        rst_n = 1'b1;
        tx_busy = 1'b0;
        tick();
        chk("rd_masked", int'(rd_data), 0);
        send(61, 8'h50, 1'b1);
        do_tx(61, 8'h50, 61, 3);

        repeat (3) tick();
        chk("pending_start", q_st_cyc.size(), 0);
        chk("pending_err", q_err.size(), 0);
        chk("pending_rd", q_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
